avr_prog_mem: RTL

Program-memory responder for `avr_fetch`. It answers the fetch unit's `prog_addr` with a 16-bit instruction word on `prog_data`. It also contains a byte-serial loader that writes a program image into the array while stalling the core. It sits between the core's fetch stage and the external image source (UART/debug bridge).

---
 rtl/avr_pkg.sv | 14 +
 rtl/avr_pmem_ram.sv | 23 ++
 rtl/avr_prog_mem.sv | 126 ++++++++++++
 3 files changed

// File: rtl/avr_pkg.sv
// Shared types and constants for the AVR program memory and its byte-serial loader.
package avr_pkg;

  typedef enum logic [2:0] {
    IDLE,
    A_HI,
    D_LO,
    D_HI,
    WR
  } ld_state_e;

  localparam logic [15:0] AVR_NOP = 16'h0000;

endpackage

// File: rtl/avr_pmem_ram.sv
// Instruction word array: asynchronous read port for fetch, synchronous write port for the loader.
module avr_pmem_ram #(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem [DEPTH];

  // No reset: the program image must survive a core reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/avr_prog_mem.sv
// Program memory for avr_fetch with a byte-serial image loader that stalls the core while loading.
// Define AVR_PMEM_CSUM_EN to build the running byte checksum on ld_csum (tied to zero otherwise).
module avr_prog_mem
  import avr_pkg::*;
#(
  parameter int unsigned DEPTH = 512,
  parameter int unsigned AW    = 9
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] prog_addr,
  output logic [15:0] prog_data,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  input  logic        ld_last,
  output logic        ld_ready,
  output logic        core_hold,
  output logic        ld_done,
  output logic        ld_err,
  output logic [7:0]  ld_csum
);

  ld_state_e   state_q, state_d;
  logic [15:0] addr_q;
  logic [7:0]  lo_q;
  logic [15:0] word_q;
  logic        last_q;

  logic        accept;
  logic        abort;
  logic        we;
  logic        wr_err;
  logic        in_range;
  logic [15:0] rdata;

  assign accept   = ld_valid && ld_ready;
  assign in_range = 32'(addr_q) < DEPTH;

  // Next-state and loader strobes
  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    we      = 1'b0;
    wr_err  = 1'b0;
    case (state_q)
      IDLE: if (accept) begin
        state_d = ld_last ? IDLE : A_HI;
        abort   = ld_last;
      end
      A_HI: if (accept) begin
        state_d = ld_last ? IDLE : D_LO;
        abort   = ld_last;
      end
      D_LO: if (accept) begin
        state_d = ld_last ? IDLE : D_HI;
        abort   = ld_last;
      end
      D_HI: if (accept) state_d = WR;
      WR: begin
        we      = in_range;
        wr_err  = !in_range;
        state_d = last_q ? IDLE : D_LO;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= 16'h0000;
      lo_q      <= 8'h00;
      word_q    <= 16'h0000;
      last_q    <= 1'b0;
      ld_ready  <= 1'b1;
      core_hold <= 1'b0;
      ld_done   <= 1'b0;
      ld_err    <= 1'b0;
    end else begin
      state_q   <= state_d;
      ld_ready  <= (state_d != WR);
      core_hold <= (state_d != IDLE);
      ld_done   <= (state_q == WR) && last_q;
      if (accept) begin
        case (state_q)
          IDLE:    addr_q       <= {8'h00, ld_data};
          A_HI:    addr_q[15:8] <= ld_data;
          D_LO:    lo_q         <= ld_data;
          D_HI: begin
            word_q <= {ld_data, lo_q};
            last_q <= ld_last;
          end
          default: ;
        endcase
      end
      if (state_q == WR) addr_q <= addr_q + 16'd1;
      // Error is sticky within a load; the first byte of a fresh load clears it unless it aborts.
      if (abort || wr_err) ld_err <= 1'b1;
      else if (accept && state_q == IDLE) ld_err <= 1'b0;
    end
  end

`ifdef AVR_PMEM_CSUM_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ld_csum <= 8'h00;
    else if (accept) ld_csum <= (state_q == IDLE) ? ld_data : 8'(ld_csum + ld_data);
  end
`else
  assign ld_csum = 8'h00;
`endif

  avr_pmem_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (CLK),
    .we    (we),
    .waddr (addr_q[AW-1:0]),
    .wdata (word_q),
    .raddr (prog_addr[AW-1:0]),
    .rdata (rdata)
  );

  assign prog_data = (32'(prog_addr) < DEPTH) ? rdata : AVR_NOP;

endmodule
